// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   state_e     : arbiter FSM states (IDLE, ACCESS, RDATA, RESP)
//   DEF_WIDTH   : default data word width
//   DEF_DEPTH   : default RAM depth in words
package data_mem_arbiter_pkg;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Core-side and RAM-side bus of the data memory arbiter.
//   req/reqWrEn/reqAddr/reqData : per-core requests (core i at slice i)
//   ack/rdData/busy             : completion pulse, load data, FSM activity
//   mem_wrEn/mem_addr/mem_dataIn/mem_dataOut : single-port RAM
// slave modport is the arbiter; master modport is the cores + RAM.
interface data_mem_arbiter_if import data_mem_arbiter_pkg::*; #(
  parameter int CORES      = 4,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEF_DEPTH)
);
  logic [CORES-1:0]            req;
  logic [CORES-1:0]            reqWrEn;
  logic [CORES*ADDR_WIDTH-1:0] reqAddr;
  logic [CORES*WIDTH-1:0]      reqData;
  logic [CORES-1:0]            ack;
  logic [WIDTH-1:0]            rdData;
  logic                        busy;
  logic                        mem_wrEn;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [WIDTH-1:0]            mem_dataIn;
  logic [WIDTH-1:0]            mem_dataOut;

  modport slave (
    input  req, reqWrEn, reqAddr, reqData, mem_dataOut,
    output ack, rdData, busy, mem_wrEn, mem_addr, mem_dataIn
  );

  modport master (
    output req, reqWrEn, reqAddr, reqData, mem_dataOut,
    input  ack, rdData, busy, mem_wrEn, mem_addr, mem_dataIn
  );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin search.
//   req   : request vector
//   ptr   : index where the search starts
//   grant : one-hot winner
//   idx   : encoded winner index
//   any   : at least one request present
module data_mem_arbiter_rr_arbiter #(
  parameter int CORES = 4,
  parameter int IDX_W = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [CORES-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < CORES; k++) begin
      pos = IDX_W'((32'(ptr) + k) % CORES);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin front end for a single-port data RAM shared by CORES cores.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of data_mem_arbiter_if (core requests, ack,
//              rdData, busy and the registered RAM port)
// One transaction at a time: IDLE -> ACCESS -> RESP for stores,
// IDLE -> ACCESS -> RDATA -> RESP for loads; ack pulses during RESP.
module data_mem_arbiter import data_mem_arbiter_pkg::*; #(
  parameter int CORES      = 4,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);
  localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [CORES-1:0]      winner_oh_q, winner_oh_d;
  logic                  wr_q, wr_d;
  logic [CORES-1:0]      ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_data_in_q, mem_data_in_d;

  logic [CORES-1:0]      gnt_oh;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_any;

  data_mem_arbiter_rr_arbiter #(
    .CORES (CORES),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (gnt_oh),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    winner_d      = winner_q;
    winner_oh_d   = winner_oh_q;
    wr_d          = wr_q;
    ack_d         = '0;
    rd_data_d     = rd_data_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          winner_d      = gnt_idx;
          winner_oh_d   = gnt_oh;
          wr_d          = bus.reqWrEn[gnt_idx];
          mem_wr_en_d   = bus.reqWrEn[gnt_idx];
          mem_addr_d    = bus.reqAddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_data_in_d = bus.reqData[gnt_idx*WIDTH +: WIDTH];
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        // ack is registered, so it is loaded on the edge entering RESP.
        if (wr_q) begin
          ack_d   = winner_oh_q;
          state_d = RESP;
        end else begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        rd_data_d = bus.mem_dataOut;
        ack_d     = winner_oh_q;
        state_d   = RESP;
      end
      RESP: begin
        if (32'(winner_q) == 32'(CORES - 1)) ptr_d = '0;
        else                                 ptr_d = winner_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      winner_q      <= '0;
      winner_oh_q   <= '0;
      wr_q          <= 1'b0;
      ack_q         <= '0;
      busy_q        <= 1'b0;
      rd_data_q     <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      winner_q      <= winner_d;
      winner_oh_q   <= winner_oh_d;
      wr_q          <= wr_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      rd_data_q     <= rd_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.rdData     = rd_data_q;
  assign bus.mem_wrEn   = mem_wr_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_dataIn = mem_data_in_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with 4 cores, 12-bit data, 4096 words.
module tb_data_mem_arbiter;
  localparam int CORES = 4;
  localparam int W     = 12;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.CORES(CORES), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(
    .CORES      (CORES),
    .WIDTH      (W),
    .DEPTH      (4096),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM with registered address: data appears the cycle after capture.
  logic [W-1:0]  ram [4096];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (bus.mem_wrEn) ram[bus.mem_addr] <= bus.mem_dataIn;
    ram_addr_q <= bus.mem_addr;
  end
  assign bus.mem_dataOut = ram[ram_addr_q];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          core;
    logic [W-1:0] exp_rd;
  } exp_t;
  exp_t sb[$];

  int           wr_total = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [W-1:0]  last_wr_data = '0;

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.mem_wrEn) begin
      wr_total++;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_dataIn;
    end
    if (bus.ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_core", 32'(bus.ack), 32'(1) << e.core);
        check("rd_data", 32'(bus.rdData), 32'(e.exp_rd));
      end
    end
  end

  typedef struct {
    int            core;
    bit            wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_rd;
  } vec_t;
  vec_t vecs[10];

  // Called just after a rising edge with the FSM idle.
  task automatic run_vec(input vec_t v);
    int lat;
    int w0;
    lat = 0;
    w0  = wr_total;
    bus.req[v.core]                = 1'b1;
    bus.reqWrEn[v.core]            = v.wr;
    bus.reqAddr[v.core*AW +: AW]   = v.addr;
    bus.reqData[v.core*W +: W]     = v.data;
    sb.push_back('{core: v.core, exp_rd: v.exp_rd});
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        check("busy_access", 32'(bus.busy), 32'd1);
        // Fields must be ignored once granted.
        bus.reqAddr[v.core*AW +: AW] = ~v.addr;
        bus.reqData[v.core*W +: W]   = ~v.data;
        bus.reqWrEn[v.core]          = ~v.wr;
      end
      if (bus.ack[v.core]) break;
    end
    check("latency", 32'(lat), v.wr ? 32'd3 : 32'd4);
    @(posedge clk); #1;
    bus.req[v.core] = 1'b0;
    check("wr_pulses", 32'(wr_total - w0), v.wr ? 32'd1 : 32'd0);
    if (v.wr) begin
      check("wr_addr", 32'(last_wr_addr), 32'(v.addr));
      check("wr_data", 32'(last_wr_data), 32'(v.data));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Waits for n_exp acks, each 4 cycles apart starting from the request.
  task automatic collect(input int n_exp, input bit drop_each);
    int n;
    int cyc;
    int last;
    logic [CORES-1:0] m;
    n = 0; cyc = 0; last = 0;
    while (n < n_exp && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        check("ack_gap", 32'(cyc - last), 32'd4);
        last = cyc;
        n++;
        m = bus.ack;
        if (n == n_exp) begin
          @(posedge clk); #1;
          bus.req = '0;
        end else if (drop_each) begin
          @(posedge clk); #1;
          bus.req = bus.req & ~m;
        end
      end
    end
    check("acks_seen", 32'(n), 32'(n_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},    32'(bus.ack),        32'd0);
    check({tag, "_busy"},   32'(bus.busy),       32'd0);
    check({tag, "_rdData"}, 32'(bus.rdData),     32'd0);
    check({tag, "_wrEn"},   32'(bus.mem_wrEn),   32'd0);
    check({tag, "_addr"},   32'(bus.mem_addr),   32'd0);
    check({tag, "_dataIn"}, 32'(bus.mem_dataIn), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] before9;
    int lat;

    vecs[0] = '{core: 1, wr: 1'b1, addr: 12'd5,    data: 12'hABC, exp_rd: 12'h000};
    vecs[1] = '{core: 1, wr: 1'b0, addr: 12'd5,    data: 12'h000, exp_rd: 12'hABC};
    vecs[2] = '{core: 0, wr: 1'b1, addr: 12'd100,  data: 12'h123, exp_rd: 12'hABC};
    vecs[3] = '{core: 3, wr: 1'b0, addr: 12'd100,  data: 12'h000, exp_rd: 12'h123};
    vecs[4] = '{core: 2, wr: 1'b1, addr: 12'd4095, data: 12'hFFF, exp_rd: 12'h123};
    vecs[5] = '{core: 0, wr: 1'b0, addr: 12'd4095, data: 12'h000, exp_rd: 12'hFFF};
    vecs[6] = '{core: 3, wr: 1'b1, addr: 12'd4095, data: 12'h555, exp_rd: 12'hFFF};
    vecs[7] = '{core: 2, wr: 1'b0, addr: 12'd4095, data: 12'h000, exp_rd: 12'h555};
    vecs[8] = '{core: 3, wr: 1'b1, addr: 12'd7,    data: 12'h7E7, exp_rd: 12'h555};
    vecs[9] = '{core: 1, wr: 1'b0, addr: 12'd7,    data: 12'h000, exp_rd: 12'h7E7};

    bus.req     = '0;
    bus.reqWrEn = '0;
    bus.reqAddr = '0;
    bus.reqData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Contention: all four loads at once, served 0,1,2,3.
    do_reset();
    bus.reqWrEn = '0;
    bus.reqAddr = {12'd7, 12'd4095, 12'd100, 12'd5};
    sb.push_back('{core: 0, exp_rd: 12'hABC});
    sb.push_back('{core: 1, exp_rd: 12'h123});
    sb.push_back('{core: 2, exp_rd: 12'h555});
    sb.push_back('{core: 3, exp_rd: 12'h7E7});
    bus.req = 4'b1111;
    collect(4, 1'b1);

    // Fairness: cores 0 and 2 never drop; pointer wraps 3 -> 0.
    do_reset();
    bus.reqWrEn = '0;
    bus.reqAddr = {12'd0, 12'd4095, 12'd0, 12'd5};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{core: 0, exp_rd: 12'hABC});
      sb.push_back('{core: 2, exp_rd: 12'h555});
    end
    bus.req = 4'b0101;
    collect(6, 1'b0);
    repeat (2) @(negedge clk);
    check("fair_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a store.
    before9 = ram[9];
    bus.reqWrEn[3]         = 1'b1;
    bus.reqAddr[3*AW +: AW] = 12'd9;
    bus.reqData[3*W +: W]   = 12'h3C3;
    bus.req[3]             = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_wren_high", 32'(bus.mem_wrEn), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_wren_drop", 32'(bus.mem_wrEn), 32'd0);
    check("midrst_busy_drop", 32'(bus.busy), 32'd0);
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ram_kept", 32'(ram[9]), 32'(before9));
    check_reset_outputs("midrst");
    @(posedge clk); #1;

    // Core 2 load that drops req during ACCESS.
    bus.reqWrEn[2]          = 1'b0;
    bus.reqAddr[2*AW +: AW] = 12'd4095;
    bus.req[2]              = 1'b1;
    sb.push_back('{core: 2, exp_rd: 12'h555});
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) bus.req[2] = 1'b0;
      if (bus.ack[2]) break;
    end
    check("drop_latency", 32'(lat), 32'd4);
    repeat (2) begin
      @(negedge clk);
      check("drop_no_grant_busy", 32'(bus.busy), 32'd0);
      check("drop_no_ack", 32'(bus.ack), 32'd0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shared-memory front end that sits directly upstream of the data RAM.
- Accepts load/store requests from CORES processor cores and grants one at a time using round-robin.
- Drives the RAM's single write-enable/address/data port with registered signals.
- Absorbs the RAM's registered-address read latency and returns read data and a one-cycle acknowledge to the winning core.

Parameters:
- CORES, 4, number of requesting cores (power of two not required, min 1)
- WIDTH, 12, data word width
- DEPTH, 4096, RAM depth in words
- ADDR_WIDTH, $clog2(DEPTH), address width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  CORES  per-core request; held high with stable fields until ack
- reqWrEn  in  CORES  per-core 1=store, 0=load
- reqAddr  in  CORES*ADDR_WIDTH  per-core address, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- reqData  in  CORES*WIDTH  per-core store data, same packing
- ack  out  CORES  one-hot, one-cycle completion pulse to the granted core
- rdData  out  WIDTH  load result, shared by all cores, valid when the matching ack bit is high and a load was granted
- busy  out  1  high whenever state != IDLE
- mem_wrEn  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_dataIn  out  WIDTH  RAM write data
- mem_dataOut  in  WIDTH  RAM read data; valid in the cycle after the address has been clocked into the RAM

Behaviour:
- Reset (asynchronous, immediate) values:
  - state=IDLE, rr pointer=0, winner=0
  - ack=0, busy=0, rdData=0
  - mem_wrEn=0, mem_addr=0, mem_dataIn=0
- FSM states: IDLE, ACCESS, RDATA, RESP.
- IDLE:
  - If any req is high, select a winner by round-robin starting the search at the rr pointer.
  - Latch winner index and its reqWrEn.
  - Register mem_addr, mem_dataIn and mem_wrEn (=reqWrEn of the winner) at the edge, then go to ACCESS.
  - With no request, stay in IDLE and hold mem_wrEn=0.
- ACCESS:
  - The RAM sees the registered signals; its write or address capture happens at the closing edge.
  - mem_wrEn is deasserted at that edge, so it is high for exactly one cycle.
  - Next state: RESP for a store, RDATA for a load.
- RDATA:
  - mem_dataOut is valid; capture it into rdData at the closing edge.
  - Go to RESP.
- RESP:
  - ack[winner]=1 for this cycle only.
  - rr pointer <= (winner+1) mod CORES.
  - Go to IDLE.
- Latency from a request being seen in IDLE to its ack: store 3 cycles, load 4 cycles.
- Throughput: at most one transaction per 3 (store) or 4 (load) cycles.
- Request field sampling:
  - reqAddr, reqData and reqWrEn are sampled only at the IDLE grant edge.
  - Later changes are ignored until the next grant.
- Core drops req before its ack:
  - The transaction still completes and ack still pulses.
  - No new grant is made until the FSM returns to IDLE.
- Because ack is registered in RESP and the FSM re-arbitrates only in IDLE, a core that drops req on the ack edge is never double-granted.
- rdData holds its value until the next load's RDATA capture. Stores do not modify it.
- Store followed by load to the same address returns the stored value; no forwarding is needed because the transactions are serialized.
- Reset mid-operation:
  - Any in-flight transaction is abandoned and no ack is produced.
  - mem_wrEn drops immediately, so a store whose ACCESS cycle has not yet reached its closing edge is not written.
- Wrap-around: the rr pointer wraps from CORES-1 to 0.
- CORES=1: the arbiter degenerates to a fixed grant.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams (IDLE, ACCESS, RDATA, RESP)
  - default WIDTH/DEPTH values
- Sub-module rr_arbiter: req vector and pointer in; one-hot grant plus encoded index out; purely combinational search.
- Pointer register stays in the parent.

Test Plan:
- Single store: core1 stores 12'hABC at addr 5 -> mem_wrEn high exactly 1 cycle, mem_addr=5, ack[1] 3 cycles after req; then core1 loads addr 5 -> ack[1] after 4 cycles with rdData=12'hABC.
- Contention: all 4 cores assert loads at the same cycle after reset -> grants in order 0,1,2,3, each ack separated by 4 cycles, rdData matching each core's address contents.
- Fairness: core0 and core2 keep reasserting req continuously -> acks alternate 0,2,0,2 with no starvation; rr pointer wraps from 3 to 0.
- Mid-op reset: core3 store granted, rst asserted during ACCESS before the edge -> mem_wrEn=0 immediately, memory word unchanged, no ack; after release all outputs are at reset values.
- Early req drop: core2 load granted, req[2] dropped in ACCESS -> ack[2] still pulses in RESP, next idle cycle grants no one.
- Boundary address: store/load at addr DEPTH-1 with data 12'hFFF -> read back 12'hFFF; rdData unchanged by an intervening store.
